gshare_predictor: RTL and testbench

- Prediction (read) side of the 2-bit saturating branch counter scheme; the training side feeds it.
- Holds a table of 2-bit counters, indexed by PC XOR global branch history (gshare).
- The fetch stage queries it combinationally each cycle; the execute stage trains it and repairs the history register on a mispredict.

---
 rtl/gshare_if.sv | 27 ++
 rtl/gshare_predictor.sv | 61 ++++++
 tb/tb_gshare_predictor.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gshare_if.sv
// Fetch/execute-side bundle for the gshare predictor: prediction query and
// training/repair channel.
interface gshare_if #(
   parameter int N_BITS = 7
);
   logic              predict_valid;
   logic [N_BITS-1:0] predict_pc;
   logic              predict_taken;
   logic [N_BITS-1:0] predict_history;
   logic              train_valid;
   logic              train_taken;
   logic              train_mispredicted;
   logic [N_BITS-1:0] train_history;
   logic [N_BITS-1:0] train_pc;

   modport master (
      output predict_valid, predict_pc,
      input  predict_taken, predict_history,
      output train_valid, train_taken, train_mispredicted, train_history, train_pc
   );

   modport slave (
      input  predict_valid, predict_pc,
      output predict_taken, predict_history,
      input  train_valid, train_taken, train_mispredicted, train_history, train_pc
   );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: a table of 2-bit saturating counters indexed by
// PC XOR global history, with combinational lookup and registered training.
module gshare_predictor #(
   parameter int N_BITS = 7
) (
   input  logic     clk,
   input  logic     areset_n,
   gshare_if.slave  bus
);
   localparam int DEPTH = 2 ** N_BITS;

   logic [1:0]        pht_q [DEPTH];
   logic [1:0]        pht_d [DEPTH];
   logic [N_BITS-1:0] ghr_q;
   logic [N_BITS-1:0] ghr_d;
   logic [N_BITS-1:0] predict_idx;
   logic [N_BITS-1:0] train_idx;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
      else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
   endfunction

   assign predict_idx         = bus.predict_pc ^ ghr_q;
   assign train_idx           = bus.train_pc ^ bus.train_history;
   // Lookup reads the registered table, so a same-cycle train is seen next cycle.
   assign bus.predict_taken   = pht_q[predict_idx][1];
   assign bus.predict_history = ghr_q;

   always_comb begin
      pht_d = pht_q;
      if (bus.train_valid) begin
         pht_d[train_idx] = sat_update(pht_q[train_idx], bus.train_taken);
      end
   end

   always_comb begin
      ghr_d = ghr_q;
      // Mispredict recovery overrides any speculative shift from fetch.
      if (bus.train_valid && bus.train_mispredicted) begin
         ghr_d = {bus.train_history[N_BITS-2:0], bus.train_taken};
      end else if (bus.predict_valid) begin
         ghr_d = {ghr_q[N_BITS-2:0], bus.predict_taken};
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         // NOTE: the table is a flop array (not a RAM) precisely so every entry
         // can be forced to weakly-not-taken by the asynchronous reset.
         for (int i = 0; i < DEPTH; i++) begin
            pht_q[i] <= 2'b01;
         end
         ghr_q <= '0;
      end else begin
         // NOTE: non-blocking here so every flop samples pre-edge values.
         pht_q <= pht_d;
         ghr_q <= ghr_d;
      end
   end
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor with hand-computed
// expected counter and history values.
module tb_gshare_predictor;
   localparam int N_BITS = 7;

   logic clk = 1'b0;
   logic areset_n;
   always #5 clk = ~clk;

   gshare_if #(.N_BITS(N_BITS)) bus ();
   gshare_predictor #(.N_BITS(N_BITS)) dut (.clk(clk), .areset_n(areset_n), .bus(bus));

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.predict_valid      = 1'b0;
      bus.predict_pc         = '0;
      bus.train_valid        = 1'b0;
      bus.train_taken        = 1'b0;
      bus.train_mispredicted = 1'b0;
      bus.train_history      = '0;
      bus.train_pc           = '0;
   endtask

   task automatic train(input logic [6:0] pc, input logic [6:0] hist,
                        input logic taken, input logic mis);
      bus.train_valid        = 1'b1;
      bus.train_pc           = pc;
      bus.train_history      = hist;
      bus.train_taken        = taken;
      bus.train_mispredicted = mis;
   endtask

   // Advance one clock edge; inputs return to idle at the following negedge.
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      idle();
   endtask

   initial begin
      logic [6:0] idx_list [4];
      idx_list = '{7'h05, 7'h0A, 7'h2A, 7'h03};
      idle();
      areset_n = 1'b1;
      #2 areset_n = 1'b0;
      #1;
      check("rst_taken", 32'(bus.predict_taken), 32'h0);
      check("rst_hist", 32'(bus.predict_history), 32'h0);
      @(negedge clk);
      areset_n = 1'b1;

      // Test 1: first prediction after reset shifts in a 0.
      bus.predict_valid = 1'b1;
      bus.predict_pc    = 7'h05;
      #1;
      check("t1_taken", 32'(bus.predict_taken), 32'h0);
      check("t1_hist", 32'(bus.predict_history), 32'h00);
      cycle();
      #1 check("t1_ghr_after", 32'(bus.predict_history), 32'h00);

      // Test 2: four correct taken trains on index 0x05 saturate at 11.
      for (int k = 0; k < 4; k++) begin
         train(7'h05, 7'h00, 1'b1, 1'b0);
         cycle();
         if (k == 0) begin
            bus.predict_pc = 7'h05;
            #1 check("t2_after_one", 32'(bus.predict_taken), 32'h1);
         end
      end
      bus.predict_pc = 7'h05;
      #1;
      check("t2_sat_taken", 32'(bus.predict_taken), 32'h1);
      check("t2_ghr_untouched", 32'(bus.predict_history), 32'h00);
      train(7'h05, 7'h00, 1'b0, 1'b0);   // 11 -> 10 only if it saturated
      cycle();
      bus.predict_pc = 7'h05;
      #1 check("t2_no_wrap", 32'(bus.predict_taken), 32'h1);

      // Test 3: index 0x0A driven to 00 then not-taken again stays 00.
      train(7'h0A, 7'h00, 1'b0, 1'b0);
      cycle();
      train(7'h0A, 7'h00, 1'b0, 1'b0);
      cycle();
      bus.predict_pc = 7'h0A;
      #1 check("t3_floor", 32'(bus.predict_taken), 32'h0);
      train(7'h0A, 7'h00, 1'b1, 1'b0);   // 00 -> 01 (would be 11 had it wrapped)
      cycle();
      bus.predict_pc = 7'h0A;
      #1 check("t3_no_underflow", 32'(bus.predict_taken), 32'h0);
      train(7'h0A, 7'h00, 1'b0, 1'b0);   // back to 00
      cycle();

      // Test 5: read-during-write on index 0x03 returns the old counter.
      bus.predict_valid = 1'b1;
      bus.predict_pc    = 7'h03;
      train(7'h03, 7'h00, 1'b1, 1'b0);
      #1 check("t5_rdw_old", 32'(bus.predict_taken), 32'h0);
      cycle();
      bus.predict_pc = 7'h03;
      #1;
      check("t5_rdw_new", 32'(bus.predict_taken), 32'h1);
      check("t5_ghr", 32'(bus.predict_history), 32'h00);

      // Test 4: recovery priority over a same-cycle prediction.
      train(7'h2A, 7'h00, 1'b1, 1'b0);
      cycle();
      train(7'h2A, 7'h00, 1'b1, 1'b0);   // PHT[0x2A] = 11
      cycle();
      train(7'h40, 7'h15, 1'b0, 1'b1);   // recovery: {0x15[5:0],0} = 0x2A
      cycle();
      #1 check("t4_recover", 32'(bus.predict_history), 32'h2A);
      bus.predict_valid = 1'b1;
      bus.predict_pc    = 7'h00;          // index 0x2A
      train(7'h01, 7'h11, 1'b0, 1'b1);
      #1 check("t4_pred_taken", 32'(bus.predict_taken), 32'h1);
      cycle();
      #1 check("t4_recovery_wins", 32'(bus.predict_history), 32'h22);
      bus.predict_valid = 1'b1;
      bus.predict_pc    = 7'h08;          // 0x08 ^ 0x22 = 0x2A
      #1 check("t4_pred_taken2", 32'(bus.predict_taken), 32'h1);
      cycle();
      #1 check("t4_spec_shift", 32'(bus.predict_history), 32'h45);
      bus.train_mispredicted = 1'b1;      // ignored: train_valid low
      bus.train_history      = 7'h7F;
      bus.train_taken        = 1'b1;
      cycle();
      #1 check("t4_hold_ignored", 32'(bus.predict_history), 32'h45);
      train(7'h10, 7'h45, 1'b1, 1'b0);   // correct train leaves GHR alone
      cycle();
      #1 check("t4_correct_train", 32'(bus.predict_history), 32'h45);

      // Test 6: asynchronous reset between edges, with a train pending.
      bus.predict_pc = 7'h6F;             // 0x6F ^ 0x45 = 0x2A (counter 11)
      #1 check("t6_pre_reset", 32'(bus.predict_taken), 32'h1);
      train(7'h2A, 7'h00, 1'b1, 1'b1);
      #1 areset_n = 1'b0;
      #1;
      check("t6_async_taken", 32'(bus.predict_taken), 32'h0);
      check("t6_async_hist", 32'(bus.predict_history), 32'h00);
      @(posedge clk);
      @(negedge clk);
      idle();
      areset_n = 1'b1;
      for (int i = 0; i < 2 ** N_BITS; i++) begin
         bus.predict_pc = 7'(i);
         #1 check($sformatf("t6_entry_%02h", i), 32'(bus.predict_taken), 32'h0);
      end
      // One taken train must flip a 01 entry to predict taken.
      foreach (idx_list[j]) begin
         train(idx_list[j], 7'h00, 1'b1, 1'b0);
         cycle();
         bus.predict_pc = idx_list[j];
         #1 check($sformatf("t6_is01_%02h", idx_list[j]), 32'(bus.predict_taken), 32'h1);
      end
      check("t6_ghr_final", 32'(bus.predict_history), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
